// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Holds the arbiter FSM encodings and grant selector.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_INST_WAIT = 2'd1,
    ARB_DATA_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_gnt_e;

endpackage

// File: rtl/mem_port_arbiter_inst_line_buffer.sv
// One-entry fetch buffer: address/data/valid with hit compare.
// Invalidate takes priority over a same-cycle fill.
module inst_line_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit EN         = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_req,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  inval
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      addr_q  <= fill_addr;
      data_q  <= fill_data;
    end
  end

  assign hit = EN && valid_q && lookup_req
            && (lookup_addr == addr_q);
  assign hit_data = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store.
// One outstanding transaction; fetch buffer absorbs re-issues.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_STREAK_MAX = 4,
  parameter int IBUF_EN         = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  output logic                    inst_mem_hazard,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_mem_hazard,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int SW = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX =
    SW'(DATA_STREAK_MAX);

  arb_state_e state_q, state_d;
  arb_gnt_e   gnt;

  logic [SW-1:0]         streak_q;
  logic [ADDR_WIDTH-1:0] own_addr_q;
  logic                  own_we_q;
  logic                  lock_q;
  logic                  lock_data_q;

  logic                  ibuf_hit;
  logic [DATA_WIDTH-1:0] ibuf_data;
  logic                  eff_inst;
  logic                  accept;
  logic                  inst_done;
  logic                  data_done;
  logic                  fill;
  logic                  store_acc;

  inst_line_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .EN         (IBUF_EN != 0)
  ) u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_req  (inst_req),
    .lookup_addr (inst_addr),
    .hit         (ibuf_hit),
    .hit_data    (ibuf_data),
    .fill        (fill),
    .fill_addr   (own_addr_q),
    .fill_data   (mem_rdata),
    .inval       (store_acc)
  );

  assign eff_inst = inst_req && !ibuf_hit;

  // A winner left waiting on mem_ready keeps the port
  // for as long as it still requests.
  always_comb begin
    gnt = GNT_NONE;
    if (state_q == ARB_IDLE && !rst) begin
      if (lock_q && lock_data_q && data_req)
        gnt = GNT_DATA;
      else if (lock_q && !lock_data_q && eff_inst)
        gnt = GNT_INST;
      else if (data_req &&
               !(streak_q == STREAK_MAX && eff_inst))
        gnt = GNT_DATA;
      else if (eff_inst)
        gnt = GNT_INST;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      (gnt == GNT_DATA): begin
        mem_req   = 1'b1;
        mem_we    = data_we;
        mem_wstrb = data_we ? data_wstrb : '0;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      (gnt == GNT_INST): begin
        mem_req  = 1'b1;
        mem_addr = inst_addr;
      end
      default: ;
    endcase
  end

  assign accept    = mem_req && mem_ready;
  assign store_acc = accept && (gnt == GNT_DATA)
                  && data_we;

  assign inst_done = (state_q == ARB_INST_WAIT)
                  && mem_rvalid;
  assign data_done = (state_q == ARB_DATA_WAIT)
                  && mem_rvalid;

  // A flushed owner gets no fill; response is dropped.
  assign fill = inst_done && inst_req && !own_we_q;

  assign inst_mem_hazard = inst_req && !ibuf_hit
                        && !inst_done;
  assign data_mem_hazard = data_req && !data_done;

  always_comb begin
    inst_rdata = '0;
    data_rdata = '0;
    if (ibuf_hit)
      inst_rdata = ibuf_data;
    else if (inst_done && inst_req)
      inst_rdata = mem_rdata;
    if (data_done && data_req)
      data_rdata = mem_rdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:
        if (accept)
          state_d = (gnt == GNT_DATA) ?
                    ARB_DATA_WAIT : ARB_INST_WAIT;
      ARB_INST_WAIT,
      ARB_DATA_WAIT:
        if (mem_rvalid)
          state_d = ARB_IDLE;
      default:
        state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      streak_q    <= '0;
      own_addr_q  <= '0;
      own_we_q    <= 1'b0;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= mem_req && !mem_ready;
      lock_data_q <= (gnt == GNT_DATA);
      if (accept) begin
        own_addr_q <= mem_addr;
        own_we_q   <= mem_we;
      end
      if (!eff_inst || (accept && gnt == GNT_INST))
        streak_q <= '0;
      else if (accept && gnt == GNT_DATA &&
               streak_q != STREAK_MAX)
        streak_q <= streak_q + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Memory model logs acceptances and answers after lat cycles.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_mem_hazard;
  logic        data_req = 1'b0;
  logic        data_we = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_mem_hazard;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] exp_q[$];

  int          lat = 3;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [31:0] cur_addr = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .DATA_STREAK_MAX (4),
    .IBUF_EN         (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_rdata      (inst_rdata),
    .inst_mem_hazard (inst_mem_hazard),
    .data_req        (data_req),
    .data_we         (data_we),
    .data_wstrb      (data_wstrb),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_rdata      (data_rdata),
    .data_mem_hazard (data_mem_hazard),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata)
  );

  function automatic logic [31:0] mdata(
    input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // The model is deliberately not reset, so an in-flight
  // response can arrive after the DUT is reset.
  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (busy) begin
      if (cnt <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mdata(cur_addr);
        busy       <= 1'b0;
      end
      cnt <= cnt - 1;
    end else if (mem_req && mem_ready) begin
      acc_q.push_back({mem_we, mem_addr});
      cur_addr <= mem_addr;
      busy     <= 1'b1;
      cnt      <= lat - 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low(input bit is_data,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((is_data ? data_mem_hazard
                   : inst_mem_hazard) === 1'b0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    inst_req = 1'b1;
    inst_addr = 32'h100;
    data_req = 1'b1;
    data_we = 1'b1;
    data_wstrb = 4'hF;
    data_addr = 32'h2000;
    data_wdata = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_wstrb} !== 6'b0) begin
      n_fail++;
      $display("FAIL rst_mem_ctl: got %b want 0",
               {mem_req, mem_we, mem_wstrb});
    end
    n_tests++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mem_bus: got %h want 0",
               {mem_addr, mem_wdata});
    end
    n_tests++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h want 0",
               {inst_rdata, data_rdata});
    end
    n_tests++;
    if ({inst_mem_hazard, data_mem_hazard} !== 2'b11)
    begin
      n_fail++;
      $display("FAIL rst_hazard: got %b want 11",
               {inst_mem_hazard, data_mem_hazard});
    end
    data_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({inst_mem_hazard, data_mem_hazard} !== 2'b10)
    begin
      n_fail++;
      $display("FAIL rst_hazard_req: got %b want 10",
               {inst_mem_hazard, data_mem_hazard});
    end
    inst_req = 1'b0;
    data_we = 1'b0;
    data_wstrb = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    int hi;
    bit ok;
    lat = 3;
    tick();
    inst_addr = 32'h100;
    inst_req = 1'b1;
    exp_q.push_back(32'h00500093);
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_addr} !==
        {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL fetch_issue: got %b/%b/%h want 1/0/100",
               mem_req, mem_we, mem_addr);
    end
    hi = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (inst_mem_hazard === 1'b0) ok = 1'b1;
      else begin
        hi++;
        @(negedge clk);
      end
    end
    n_tests++;
    if (!ok || hi != 3) begin
      n_fail++;
      $display("FAIL fetch_latency: got %0d want 3 (done=%0d)",
               hi, ok);
    end
    n_tests++;
    if (inst_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h want %h",
               inst_rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_ibuf_hit;
    int n0;
    n0 = acc_q.size();
    tick();
    @(negedge clk);
    n_tests++;
    if ({inst_mem_hazard, mem_req, inst_rdata} !==
        {1'b0, 1'b0, 32'h00500093}) begin
      n_fail++;
      $display("FAIL ibuf_hit: got %b/%b/%h want 0/0/00500093",
               inst_mem_hazard, mem_req, inst_rdata);
    end
    tick();
    tick();
    @(negedge clk);
    n_tests++;
    if (acc_q.size() != n0) begin
      n_fail++;
      $display("FAIL ibuf_no_access: got %0d want %0d",
               acc_q.size(), n0);
    end
    tick();
    inst_req = 1'b0;
  endtask

  task automatic test_priority;
    bit ok;
    lat = 2;
    tick();
    inst_req = 1'b1;
    inst_addr = 32'h140;
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h2000;
    data_wstrb = 4'hF;
    data_wdata = 32'h12345678;
    exp_q.push_back(mdata(32'h2000));
    exp_q.push_back(mdata(32'h140));
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr,
         inst_mem_hazard} !==
        {1'b1, 1'b0, 4'h0, 32'h2000, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_data_first: got %b/%b/%h/%h/%b",
               mem_req, mem_we, mem_wstrb, mem_addr,
               inst_mem_hazard);
    end
    wait_low(1'b1, ok);
    n_tests++;
    if (!ok || data_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL prio_data_rdata: got %h want %h (done=%0d)",
               data_rdata, exp_q[0], ok);
    end
    void'(exp_q.pop_front());
    tick();
    data_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h140}) begin
      n_fail++;
      $display("FAIL prio_fetch_next: got %b/%h want 1/140",
               mem_req, mem_addr);
    end
    wait_low(1'b0, ok);
    n_tests++;
    if (!ok || inst_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL prio_fetch_rdata: got %h want %h (done=%0d)",
               inst_rdata, exp_q[0], ok);
    end
    void'(exp_q.pop_front());
    tick();
    inst_req = 1'b0;
    data_wstrb = 4'h0;
  endtask

  task automatic test_streak;
    acc_t gexp[$];
    acc_t got;
    acc_t want;
    int   dcnt;
    int   icnt;
    bit   d_done;
    bit   i_done;
    lat = 2;
    acc_q.delete();
    for (int k = 0; k < 4; k++)
      gexp.push_back({1'b0, 32'h3000 + 32'(k * 4)});
    gexp.push_back({1'b0, 32'h180});
    for (int k = 4; k < 8; k++)
      gexp.push_back({1'b0, 32'h3000 + 32'(k * 4)});
    gexp.push_back({1'b0, 32'h184});
    tick();
    inst_req = 1'b1;
    inst_addr = 32'h180;
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h3000;
    dcnt = 0;
    icnt = 0;
    for (int i = 0; i < 200 && (dcnt < 8 || icnt < 2);
         i++) begin
      @(negedge clk);
      d_done = data_req && !data_mem_hazard;
      i_done = inst_req && !inst_mem_hazard;
      tick();
      if (d_done) begin
        dcnt++;
        if (dcnt == 8) data_req = 1'b0;
        else data_addr = 32'h3000 + 32'(dcnt * 4);
      end
      if (i_done) begin
        icnt++;
        if (icnt == 2) inst_req = 1'b0;
        else inst_addr = 32'h184;
      end
    end
    n_tests++;
    if (dcnt != 8 || icnt != 2) begin
      n_fail++;
      $display("FAIL streak_timeout: got %0d/%0d want 8/2",
               dcnt, icnt);
    end
    for (int k = 0; k < 10; k++) begin
      want = gexp.pop_front();
      got = (acc_q.size() > 0) ? acc_q.pop_front() : '1;
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL streak_grant%0d: got %h want %h",
                 k, got, want);
      end
    end
  endtask

  task automatic test_store_inval;
    bit ok;
    lat = 2;
    tick();
    inst_req = 1'b1;
    inst_addr = 32'h100;
    @(negedge clk);
    wait_low(1'b0, ok);
    n_tests++;
    if (!ok || inst_rdata !== 32'h00500093) begin
      n_fail++;
      $display("FAIL st_prefetch: got %h want 00500093 (done=%0d)",
               inst_rdata, ok);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({inst_mem_hazard, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL st_buffered: got %b want 00",
               {inst_mem_hazard, mem_req});
    end
    tick();
    inst_req = 1'b0;
    data_req = 1'b1;
    data_we = 1'b1;
    data_addr = 32'h2000;
    data_wstrb = 4'h6;
    data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata}
        !== {1'b1, 1'b1, 4'h6, 32'h2000, 32'hDEADBEEF})
    begin
      n_fail++;
      $display("FAIL st_issue: got %b/%b/%h/%h/%h",
               mem_req, mem_we, mem_wstrb, mem_addr,
               mem_wdata);
    end
    wait_low(1'b1, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL st_ack: got timeout want ack");
    end
    tick();
    data_req = 1'b0;
    data_we = 1'b0;
    data_wstrb = 4'h0;
    inst_req = 1'b1;
    inst_addr = 32'h100;
    exp_q.push_back(32'h00500093);
    @(negedge clk);
    n_tests++;
    if ({inst_mem_hazard, mem_req, mem_addr} !==
        {1'b1, 1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL st_refetch: got %b/%b/%h want 1/1/100",
               inst_mem_hazard, mem_req, mem_addr);
    end
    wait_low(1'b0, ok);
    n_tests++;
    if (!ok || inst_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL st_refetch_rdata: got %h want %h",
               inst_rdata, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick();
    inst_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    int drops;
    int req_bad;
    bit seen;
    bit ok;
    lat = 6;
    tick();
    data_req = 1'b1;
    data_we = 1'b0;
    data_addr = 32'h2400;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_issue: got %b want 1", mem_req);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({data_mem_hazard, mem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL rm_in_reset: got %b want 10",
               {data_mem_hazard, mem_req});
    end
    tick();
    mem_ready = 1'b0;
    rst = 1'b0;
    drops = 0;
    req_bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mem_rvalid === 1'b1) seen = 1'b1;
      if (data_mem_hazard !== 1'b1) drops++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h2400})
        req_bad++;
    end
    n_tests++;
    if (!seen || drops != 0) begin
      n_fail++;
      $display("FAIL rm_stray: got drops=%0d seen=%0d want 0/1",
               drops, seen);
    end
    n_tests++;
    if (req_bad != 0) begin
      n_fail++;
      $display("FAIL rm_new_req: got %0d bad cycles want 0",
               req_bad);
    end
    tick();
    mem_ready = 1'b1;
    exp_q.push_back(mdata(32'h2400));
    @(negedge clk);
    wait_low(1'b1, ok);
    n_tests++;
    if (!ok || data_rdata !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rm_rdata: got %h want %h (done=%0d)",
               data_rdata, exp_q[0], ok);
    end
    void'(exp_q.pop_front());
    tick();
    data_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_ibuf_hit();
    test_priority();
    test_streak();
    test_store_inval();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
